// File: rtl/ram_mfc_controller.sv
// Bridges the processor RAM1 request/MFC handshake onto a synchronous RAM macro.
// Range-checks word addresses and times reads and writes with a down-counter.
module ram_mfc_controller #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int WRITE_CYCLES = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [31:0]           RAM1_Address,
  input  logic                  RAM1_Read_H_Write_L,
  input  logic                  RAM1_Out_Enable,
  input  logic [DATA_WIDTH-1:0] RAM1_Data_In,
  output logic [DATA_WIDTH-1:0] RAM1_Data_Out,
  output logic                  RAM1_MFC,
  output logic                  RAM1_Addr_Err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]            cnt;
  logic [2:0]            cnt_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx;
  logic [DATA_WIDTH-1:0] dout_nx;
  logic                  wren_nx;
  logic                  mfc_nx;
  logic                  err_nx;

  logic range_err;
  logic last;
  logic req;

  assign req       = RAM1_Out_Enable;
  assign range_err = |RAM1_Address[31:ADDR_WIDTH];
  assign last      = (cnt == 3'd1);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (range_err) begin
            state_nx = DONE;
          end else if (RAM1_Read_H_Write_L) begin
            state_nx = RD;
          end else begin
            state_nx = WR;
          end
        end
      end
      RD: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      WR: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!req) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values for counter, RAM-side and processor-side outputs
  always_comb begin
    cnt_nx   = cnt;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    dout_nx  = RAM1_Data_Out;
    err_nx   = RAM1_Addr_Err;
    wren_nx  = 1'b0;
    mfc_nx   = (state_nx == DONE);
    unique case (state)
      IDLE: begin
        if (req) begin
          if (range_err) begin
            err_nx  = 1'b1;
            dout_nx = '0;
          end else if (RAM1_Read_H_Write_L) begin
            addr_nx = RAM1_Address[ADDR_WIDTH-1:0];
            cnt_nx  = 3'(READ_LATENCY);
          end else begin
            addr_nx  = RAM1_Address[ADDR_WIDTH-1:0];
            wdata_nx = RAM1_Data_In;
            wren_nx  = 1'b1;
            cnt_nx   = 3'(WRITE_CYCLES);
          end
        end
      end
      RD: begin
        if (last) begin
          dout_nx = mem_rdata;
          cnt_nx  = 3'd0;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      WR: begin
        if (last) begin
          cnt_nx = 3'd0;
        end else begin
          wren_nx = 1'b1;
          cnt_nx  = cnt - 3'd1;
        end
      end
      DONE: begin
        if (!req) begin
          err_nx = 1'b0;
        end
      end
      default: begin
        cnt_nx = 3'd0;
      end
    endcase
  end

  // Registered datapath and handshake outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt           <= 3'd0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wren      <= 1'b0;
      RAM1_Data_Out <= '0;
      RAM1_MFC      <= 1'b0;
      RAM1_Addr_Err <= 1'b0;
    end else begin
      cnt           <= cnt_nx;
      mem_addr      <= addr_nx;
      mem_wdata     <= wdata_nx;
      mem_wren      <= wren_nx;
      RAM1_Data_Out <= dout_nx;
      RAM1_MFC      <= mfc_nx;
      RAM1_Addr_Err <= err_nx;
    end
  end

endmodule

// File: tb/tb_ram_mfc_controller.sv
// Randomized bench for ram_mfc_controller with a behavioural RAM model.
// Latency, data and error flags are predicted from the access rules.
module tb_ram_mfc_controller;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int WC = 1;
  localparam int DEPTH = 1 << AW;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [31:0]   RAM1_Address = '0;
  logic          RAM1_Read_H_Write_L = 1'b1;
  logic          RAM1_Out_Enable = 1'b0;
  logic [DW-1:0] RAM1_Data_In = '0;
  logic [DW-1:0] RAM1_Data_Out;
  logic          RAM1_MFC;
  logic          RAM1_Addr_Err;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] model [DEPTH];

  ram_mfc_controller #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .READ_LATENCY(RL),
    .WRITE_CYCLES(WC)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .RAM1_Address(RAM1_Address),
    .RAM1_Read_H_Write_L(RAM1_Read_H_Write_L),
    .RAM1_Out_Enable(RAM1_Out_Enable),
    .RAM1_Data_In(RAM1_Data_In),
    .RAM1_Data_Out(RAM1_Data_Out),
    .RAM1_MFC(RAM1_MFC),
    .RAM1_Addr_Err(RAM1_Addr_Err),
    .mem_addr(mem_addr),
    .mem_wren(mem_wren),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 Clock = ~Clock;

  // RAM macro: registered address path, read data two clocks after address
  always @(posedge Clock) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic rd,
                        input logic [31:0] d, input int hold,
                        input bit mutate);
    bit err;
    int n;
    int wcnt;
    bit got;
    logic [AW-1:0] waddr;
    int exp_lat;
    err = (a[31:AW] != 0);
    exp_lat = err ? 1 : (rd ? RL + 1 : WC + 1);
    @(negedge Clock);
    RAM1_Address = a;
    RAM1_Read_H_Write_L = rd;
    RAM1_Data_In = d;
    RAM1_Out_Enable = 1'b1;
    n = 0;
    wcnt = 0;
    got = 0;
    waddr = '0;
    while (n < 40 && !got) begin
      @(posedge Clock);
      #1;
      n++;
      if (n == 1) chk("busy_on", 64'(busy), 64'd1);
      if (mem_wren) begin
        wcnt++;
        waddr = mem_addr;
      end
      if (mutate && n == 1) RAM1_Data_In = 32'h12345678;
      if (RAM1_MFC) got = 1;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("addr_err", 64'(RAM1_Addr_Err), 64'(err));
    if (err) begin
      chk("err_dout", 64'(RAM1_Data_Out), 64'd0);
      chk("err_wren", 64'(wcnt), 64'd0);
    end else if (rd) begin
      chk("rdata", 64'(RAM1_Data_Out), 64'(model[a[AW-1:0]]));
      chk("rd_wren", 64'(wcnt), 64'd0);
    end else begin
      chk("wr_cycles", 64'(wcnt), 64'(WC));
      chk("wr_addr", 64'(waddr), 64'(a[AW-1:0]));
      chk("wr_data", 64'(mem_wdata), 64'(d));
      model[a[AW-1:0]] = d;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge Clock);
      #1;
      chk("mfc_hold", 64'(RAM1_MFC), 64'd1);
    end
    @(negedge Clock);
    RAM1_Out_Enable = 1'b0;
    @(posedge Clock);
    #1;
    chk("mfc_drop", 64'(RAM1_MFC), 64'd0);
    chk("idle", 64'(busy), 64'd0);
    chk("err_clr", 64'(RAM1_Addr_Err), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 32'(i) * 32'h01010101 ^ 32'hA5A5A5A5;
      model[i] = 32'(i) * 32'h01010101 ^ 32'hA5A5A5A5;
    end
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_mfc", 64'(RAM1_MFC), 64'd0);
    chk("rst_dout", 64'(RAM1_Data_Out), 64'd0);
    chk("rst_err", 64'(RAM1_Addr_Err), 64'd0);
    chk("rst_wren", 64'(mem_wren), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;

    access(32'd5, 1'b0, 32'hDEADBEEF, 0, 0);
    access(32'd5, 1'b1, 32'h0, 0, 0);
    access(32'h100, 1'b1, 32'h0, 0, 0);
    access(32'h80000007, 1'b0, 32'h55AA55AA, 0, 0);
    access(32'd9, 1'b0, 32'hCAFEF00D, 0, 1);
    access(32'd9, 1'b1, 32'h0, 0, 0);

    // reset during a read
    @(negedge Clock);
    RAM1_Address = 32'd5;
    RAM1_Read_H_Write_L = 1'b1;
    RAM1_Out_Enable = 1'b1;
    @(posedge Clock);
    #1;
    chk("rd_busy", 64'(busy), 64'd1);
    @(negedge Clock);
    Reset = 1'b1;
    RAM1_Out_Enable = 1'b0;
    @(posedge Clock);
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_mfc", 64'(RAM1_MFC), 64'd0);
    chk("abort_dout", 64'(RAM1_Data_Out), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    access(32'd5, 1'b1, 32'h0, 0, 0);

    // long hold in DONE, then immediate re-request
    access(32'd200, 1'b0, 32'h0BADC0DE, 10, 0);
    access(32'd200, 1'b1, 32'h0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      a = 32'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom();
        if (a[31:AW] == 0) a[AW] = 1'b1;
      end
      access(a, 1'($urandom_range(0, 1)), $urandom(),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_mfc_controller.md
Name: ram_mfc_controller

Overview:
- Sits between the Processor's RAM1 port group and the synchronous on-chip RAM macro inside the memory interface.
- Turns the processor's level-held request (Out_Enable, Read_H_Write_L, Address, Data_In) into a timed access on the RAM macro.
- Returns read data, and signals completion on RAM1_MFC with a full four-phase handshake.
- Flags out-of-range word addresses instead of aliasing them.

Parameters:
- ADDR_WIDTH, 8: RAM macro word-address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width.
- READ_LATENCY, 2: clocks from mem_addr presented to mem_rdata valid (1..7).
- WRITE_CYCLES, 1: clocks mem_wren is held high per write (1..7).

Ports:
- Clock  in  1  system clock; all logic rising-edge.
- Reset  in  1  synchronous, active-high reset.
- RAM1_Address  in  32  word address from the processor.
- RAM1_Read_H_Write_L  in  1  1 = read, 0 = write.
- RAM1_Out_Enable  in  1  request; held high until MFC is seen.
- RAM1_Data_In  in  DATA_WIDTH  write data.
- RAM1_Data_Out  out  DATA_WIDTH  read data; valid while MFC = 1.
- RAM1_MFC  out  1  memory-function-complete.
- RAM1_Addr_Err  out  1  address out of range; valid while MFC = 1.
- mem_addr  out  ADDR_WIDTH  RAM macro address.
- mem_wren  out  1  RAM macro write enable.
- mem_wdata  out  DATA_WIDTH  RAM macro write data.
- mem_rdata  in  DATA_WIDTH  RAM macro read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0.
- Reset asserted mid-access:
  - The next edge forces IDLE and drops mem_wren and MFC.
  - A write in progress may be partially applied; no MFC is issued for it.
- IDLE:
  - On an edge where RAM1_Out_Enable = 1, latch address, direction and data.
  - Compute the range check: error if RAM1_Address[31:ADDR_WIDTH] is nonzero.
  - Error -> go to DONE with Addr_Err = 1 and Data_Out = 0. There is no RAM access.
  - Read -> go to RD with mem_addr = latched address and counter = READ_LATENCY.
  - Write -> go to WR with mem_wren = 1, mem_addr and mem_wdata from the latch, and counter = WRITE_CYCLES.
- RD:
  - The counter decrements each clock.
  - On the edge where the counter reaches 1, capture mem_rdata into Data_Out and go to DONE.
  - Read latency from request edge to MFC high is READ_LATENCY+1 clocks.
- WR:
  - mem_wren is held for exactly WRITE_CYCLES clocks, then drops on the edge that enters DONE.
  - Write latency is WRITE_CYCLES+1 clocks.
- DONE:
  - MFC = 1. Data_Out and Addr_Err are held stable.
  - Stay until RAM1_Out_Enable = 0.
  - On that edge, clear MFC and go to IDLE. Data_Out holds its last value; Addr_Err clears.
- Input changes after acceptance: changes to the request inputs while busy are ignored.
  - Only the IDLE-edge latch matters.
- Back-to-back requests: a new request is not accepted on the same edge MFC falls.
  - The minimum gap is one IDLE clock.
- Outside WR, mem_addr holds its last value and mem_wren = 0.

Test Plan:
- Reset, then write 0xDEADBEEF to address 5 (READ_LATENCY=2, WRITE_CYCLES=1).
  - mem_wren high for exactly 1 clock with mem_addr = 5.
  - MFC high 2 clocks after the request.
  - MFC stays high until Out_Enable drops, then falls on the next edge.
- Read address 5 after that write.
  - MFC high 3 clocks after the request, Data_Out = 0xDEADBEEF, Addr_Err = 0.
- Read address 0x100 with ADDR_WIDTH = 8.
  - MFC 1 clock after the request, Addr_Err = 1, Data_Out = 0, mem_wren never asserts.
- Write request, then change Data_In to 0x12345678 one clock later.
  - mem_wdata keeps the originally latched value; a readback confirms it.
- Assert Reset during RD.
  - Next edge: busy = 0, MFC = 0, Data_Out = 0.
  - A subsequent read of the same address completes normally.
- Hold Out_Enable high through DONE for 10 clocks, then drop it and immediately re-raise it.
  - MFC stays high for all 10 clocks.
  - There is exactly one IDLE clock before the second access starts.
